lap_tracker: RTL and testbench

Downstream consumer of the physics engine's per-car position. Samples `pos_x`/`pos_y` on its own 60 Hz game tick and classifies the position into four track quadrants. It enforces forward quadrant order, counts laps, times them in ticks, flags wrong-way driving and raises `finished` after the configured lap count. One instance per car; the game FSM reads its outputs to decide the winner.

---
 rtl/lap_tracker_pkg.sv | 31 +++
 rtl/lap_tracker_tick_gen.sv | 29 ++
 rtl/lap_tracker.sv | 157 +++++++++++++++
 tb/tb_lap_tracker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lap_tracker_pkg.sv
// Shared definitions for the lap tracker: game state codes, phase encoding,
// track zone index type and the quadrant classification function.
package lap_tracker_pkg;

  // Game FSM state codes as seen on the state input
  localparam logic [2:0] ST_MENU = 3'd0;
  localparam logic [2:0] ST_RACE = 3'd4;

  // Tracker phase encoding, also driven onto the phase output
  localparam logic [1:0] PH_IDLE     = 2'd0;
  localparam logic [1:0] PH_RACING   = 2'd1;
  localparam logic [1:0] PH_FINISHED = 2'd2;

  // Track quadrant index; forward driving goes 0 -> 1 -> 2 -> 3 -> 0
  typedef logic [1:0] zone_t;

  localparam zone_t Z0 = 2'd0;
  localparam zone_t Z1 = 2'd1;
  localparam zone_t Z2 = 2'd2;
  localparam zone_t Z3 = 2'd3;

  // Classify a position into one of the four quadrants around (mid_x, mid_y)
  function automatic zone_t zone_of(input logic [9:0] x, input logic [9:0] y,
                                    input logic [9:0] mid_x, input logic [9:0] mid_y);
    zone_t z;
    if (x < mid_x) z = (y >= mid_y) ? Z0 : Z1;
    else           z = (y <  mid_y) ? Z2 : Z3;
    return z;
  endfunction

endpackage

// File: rtl/lap_tracker_tick_gen.sv
// 60 Hz game tick divider. The tick is high for one clock whenever the
// counter sits at zero, so the first tick lands right after reset releases.
module game_tick_gen #(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic game_tick
);

  localparam int PERIOD = CLK_FREQ / 60 + 1;
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] count;

  // Free-running divider counting 0 .. PERIOD-1
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (count == CW'(PERIOD - 1)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign game_tick = (count == '0);

endmodule

// File: rtl/lap_tracker.sv
// Per-car lap tracker: classifies the car position into quadrants on every
// game tick, debounces zone changes, enforces clockwise progress, counts and
// times laps and reports wrong-way driving and race completion.
module lap_tracker
  import lap_tracker_pkg::*;
#(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int MAP_W         = 320,
  parameter int MAP_H         = 240,
  parameter int LAPS          = 3,
  parameter int CONFIRM_TICKS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  state,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  output logic [2:0]  lap_cnt,
  output logic        lap_done,
  output logic        finished,
  output logic        wrong_way,
  output logic [15:0] lap_time,
  output logic [15:0] last_lap,
  output logic [15:0] best_lap,
  output logic [1:0]  phase
);

  localparam logic [9:0] MID_X = 10'(MAP_W / 2);
  localparam logic [9:0] MID_Y = 10'(MAP_H / 2);

  // Checkpoint counter limits; the upper clamp only matters for races that
  // start outside Z0, where the counter could otherwise wrap negative.
  localparam logic signed [3:0] CP_MIN = 4'sb1000;
  localparam logic signed [3:0] CP_MAX = 4'sb0111;
  localparam logic signed [3:0] CP_LAP = 4'sd3;

  logic              game_tick;
  zone_t             cur_zone;
  zone_t             cand_zone;
  logic [2:0]        cand_cnt;
  logic signed [3:0] cp_cnt;

  zone_t             zone_now;
  zone_t             fwd_zone;
  zone_t             rev_zone;
  logic [15:0]       lap_time_inc;
  logic [2:0]        cand_cnt_next;
  logic              confirm;
  logic              is_fwd;
  logic              is_rev;
  logic              lap_hit;
  logic [2:0]        lap_cnt_inc;

  game_tick_gen #(
    .CLK_FREQ (CLK_FREQ)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .game_tick (game_tick)
  );

  // Zone classification and the candidate/commit decision for this tick
  always_comb begin
    zone_now      = zone_of(pos_x, pos_y, MID_X, MID_Y);
    fwd_zone      = cur_zone + 2'd1;
    rev_zone      = cur_zone - 2'd1;
    lap_time_inc  = (lap_time == 16'hFFFF) ? lap_time : lap_time + 16'd1;
    cand_cnt_next = (zone_now == cand_zone) ? cand_cnt + 3'd1 : 3'd1;
    confirm       = (zone_now != cur_zone) && (cand_cnt_next == 3'(CONFIRM_TICKS));
    is_fwd        = (zone_now == fwd_zone);
    is_rev        = (zone_now == rev_zone);
    lap_hit       = confirm && is_fwd && (zone_now == Z0) && (cp_cnt == CP_LAP);
    lap_cnt_inc   = lap_cnt + 3'd1;
  end

  // Phase sequencing, zone debouncing, lap counting and lap timing
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase     <= PH_IDLE;
      lap_cnt   <= '0;
      lap_done  <= 1'b0;
      finished  <= 1'b0;
      wrong_way <= 1'b0;
      lap_time  <= '0;
      last_lap  <= '0;
      best_lap  <= 16'hFFFF;
      cur_zone  <= Z0;
      cand_zone <= Z0;
      cand_cnt  <= '0;
      cp_cnt    <= '0;
    end else begin
      lap_done <= 1'b0;
      if (game_tick) begin
        if (state == ST_MENU) begin
          phase    <= PH_IDLE;
          cand_cnt <= '0;
        end else begin
          case (phase)
            PH_IDLE: begin
              if (state == ST_RACE) begin
                phase     <= PH_RACING;
                cur_zone  <= zone_now;
                lap_cnt   <= '0;
                lap_time  <= '0;
                cp_cnt    <= '0;
                cand_cnt  <= '0;
                wrong_way <= 1'b0;
                finished  <= 1'b0;
              end
            end
            PH_RACING: begin
              if (state == ST_RACE) begin
                lap_time <= lap_time_inc;
                if (zone_now == cur_zone) begin
                  cand_cnt <= '0;
                end else if (!confirm) begin
                  cand_zone <= zone_now;
                  cand_cnt  <= cand_cnt_next;
                end else begin
                  cand_zone <= zone_now;
                  cand_cnt  <= '0;
                  if (is_fwd) begin
                    cur_zone  <= zone_now;
                    wrong_way <= 1'b0;
                    if (lap_hit) begin
                      lap_cnt  <= lap_cnt_inc;
                      last_lap <= lap_time_inc;
                      if (lap_time_inc < best_lap) best_lap <= lap_time_inc;
                      lap_time <= '0;
                      cp_cnt   <= '0;
                      lap_done <= 1'b1;
                      if (lap_cnt_inc == 3'(LAPS)) begin
                        phase    <= PH_FINISHED;
                        finished <= 1'b1;
                      end
                    end else if (cp_cnt != CP_MAX) begin
                      cp_cnt <= cp_cnt + 4'sd1;
                    end
                  end else if (is_rev) begin
                    cur_zone  <= zone_now;
                    wrong_way <= 1'b1;
                    if (cp_cnt != CP_MIN) cp_cnt <= cp_cnt - 4'sd1;
                  end
                end
              end else begin
                cand_cnt <= '0;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lap_tracker.sv
// Scoreboard bench for lap_tracker: the stimulus process queues expected lap
// records and output snapshots, a separate monitor pops and compares them.
module tb_lap_tracker;

  localparam int TICK_PERIOD = 600 / 60 + 1;

  typedef struct {
    string       name;
    logic [2:0]  lap_cnt;
    logic        finished;
    logic        wrong_way;
    logic [15:0] lap_time;
    logic [15:0] last_lap;
    logic [15:0] best_lap;
    logic [1:0]  phase;
    bit          skip_fin;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [2:0]  state;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic [2:0]  lap_cnt;
  logic        lap_done;
  logic        finished;
  logic        wrong_way;
  logic [15:0] lap_time;
  logic [15:0] last_lap;
  logic [15:0] best_lap;
  logic [1:0]  phase;

  int   checks = 0;
  int   errors = 0;
  int   tb_cnt = 0;
  logic tb_tick;
  logic sample_req = 1'b0;
  logic done = 1'b0;
  bit   ended = 1'b0;
  bit   prev_ld = 1'b0;

  exp_t lap_q[$];
  exp_t snap_q[$];

  lap_tracker #(
    .CLK_FREQ      (600),
    .MAP_W         (320),
    .MAP_H         (240),
    .LAPS          (3),
    .CONFIRM_TICKS (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .lap_cnt   (lap_cnt),
    .lap_done  (lap_done),
    .finished  (finished),
    .wrong_way (wrong_way),
    .lap_time  (lap_time),
    .last_lap  (last_lap),
    .best_lap  (best_lap),
    .phase     (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference tick schedule: one tick every TICK_PERIOD cycles, first right after reset
  always @(posedge clk) begin
    if (!rst) tb_cnt <= 0;
    else if (tb_cnt == TICK_PERIOD - 1) tb_cnt <= 0;
    else tb_cnt <= tb_cnt + 1;
  end
  assign tb_tick = (tb_cnt == 0);

  function automatic exp_t mk(input string n, input int lc, input int lt, input int last,
                              input int best, input int ph, input bit fin, input bit ww,
                              input bit skip_fin);
    exp_t e;
    e.name      = n;
    e.lap_cnt   = 3'(lc);
    e.lap_time  = 16'(lt);
    e.last_lap  = 16'(last);
    e.best_lap  = 16'(best);
    e.phase     = 2'(ph);
    e.finished  = fin;
    e.wrong_way = ww;
    e.skip_fin  = skip_fin;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all(input exp_t e);
    checkOutput({e.name, ".lap_cnt"},   16'(lap_cnt),   16'(e.lap_cnt));
    checkOutput({e.name, ".lap_time"},  lap_time,       e.lap_time);
    checkOutput({e.name, ".last_lap"},  last_lap,       e.last_lap);
    checkOutput({e.name, ".best_lap"},  best_lap,       e.best_lap);
    checkOutput({e.name, ".phase"},     16'(phase),     16'(e.phase));
    checkOutput({e.name, ".wrong_way"}, 16'(wrong_way), 16'(e.wrong_way));
    if (!e.skip_fin) checkOutput({e.name, ".finished"}, 16'(finished), 16'(e.finished));
  endtask

  // Waits until n game ticks have been consumed, returning just after the last tick edge
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      while (!tb_tick) @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] st, input int x, input int y, input int n);
    state = st;
    pos_x = 10'(x);
    pos_y = 10'(y);
    wait_ticks(n);
  endtask

  task automatic take_snapshot(input exp_t e);
    snap_q.push_back(e);
    sample_req = 1'b1;
    @(posedge clk);
    #1;
    sample_req = 1'b0;
  endtask

  task automatic drive_lap();
    applyStimulus(3'd4, 5,   100, 2);
    applyStimulus(3'd4, 200, 100, 2);
    applyStimulus(3'd4, 200, 200, 2);
    applyStimulus(3'd4, 5,   200, 2);
  endtask

  // Monitor: pops expected records on lap_done pulses and on snapshot requests
  always @(negedge clk) begin
    if (prev_ld) checkOutput("lap_done_width", 16'(lap_done), 16'd0);
    if (lap_done && !prev_ld) begin
      if (lap_q.size() == 0) checkOutput("unexpected_lap_done", 16'd1, 16'd0);
      else compare_all(lap_q.pop_front());
    end
    prev_ld = lap_done;
    if (sample_req) begin
      if (snap_q.size() == 0) checkOutput("snapshot_queue", 16'd0, 16'd1);
      else compare_all(snap_q.pop_front());
    end
    if (done && !ended) begin
      ended = 1'b1;
      checkOutput("missing_lap_done", 16'(lap_q.size()), 16'd0);
      checkOutput("pending_snapshots", 16'(snap_q.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  // Directed scenarios with hand-computed expectations
  initial begin
    rst   = 1'b0;
    state = 3'd0;
    pos_x = 10'd5;
    pos_y = 10'd130;
    repeat (3) @(posedge clk);
    #1;
    take_snapshot(mk("reset", 0, 0, 0, 16'hFFFF, 0, 0, 0, 0));

    $display("[TB] full lap");
    lap_q.push_back(mk("lap1", 1, 0, 13, 13, 1, 0, 0, 0));
    rst = 1'b1;
    applyStimulus(3'd4, 5,   130, 3);
    applyStimulus(3'd4, 5,   100, 3);
    applyStimulus(3'd4, 200, 100, 3);
    applyStimulus(3'd4, 200, 200, 3);
    applyStimulus(3'd4, 5,   200, 3);
    take_snapshot(mk("full_lap", 1, 1, 13, 13, 1, 0, 0, 0));

    $display("[TB] glitch filter");
    applyStimulus(3'd4, 5, 100, 1);
    applyStimulus(3'd4, 5, 130, 2);
    take_snapshot(mk("glitch", 1, 4, 13, 13, 1, 0, 0, 0));

    $display("[TB] reverse cheat");
    applyStimulus(3'd4, 200, 200, 3);
    take_snapshot(mk("reverse_out", 1, 7, 13, 13, 1, 0, 1, 0));
    applyStimulus(3'd4, 5, 130, 3);
    take_snapshot(mk("reverse_back", 1, 10, 13, 13, 1, 0, 0, 0));

    $display("[TB] finish");
    lap_q.push_back(mk("lap2", 2, 0, 18, 13, 1, 0, 0, 0));
    lap_q.push_back(mk("lap3", 3, 0, 8, 8, 2, 1, 0, 0));
    drive_lap();
    drive_lap();
    drive_lap();
    take_snapshot(mk("frozen", 3, 0, 8, 8, 2, 1, 0, 0));
    applyStimulus(3'd0, 5, 200, 1);
    take_snapshot(mk("menu", 3, 0, 8, 8, 0, 0, 0, 1));

    $display("[TB] pause");
    applyStimulus(3'd4, 5,   130, 3);
    applyStimulus(3'd4, 5,   100, 2);
    applyStimulus(3'd4, 5,   130, 1);
    take_snapshot(mk("pre_pause", 0, 5, 8, 8, 1, 0, 0, 0));
    applyStimulus(3'd3, 5,   130, 20);
    take_snapshot(mk("paused", 0, 5, 8, 8, 1, 0, 0, 0));
    applyStimulus(3'd4, 5,   130, 1);
    take_snapshot(mk("resume", 0, 6, 8, 8, 1, 0, 0, 0));
    applyStimulus(3'd4, 5,   130, 1);
    take_snapshot(mk("resume_commit", 0, 7, 8, 8, 1, 0, 1, 0));

    $display("[TB] reset mid-race");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    take_snapshot(mk("mid_reset", 0, 0, 0, 16'hFFFF, 0, 0, 0, 0));

    $display("[TB] diagonal discard");
    state = 3'd4;
    rst   = 1'b1;
    applyStimulus(3'd4, 5,   130, 1);
    applyStimulus(3'd4, 200, 100, 2);
    applyStimulus(3'd4, 200, 200, 2);
    take_snapshot(mk("diagonal", 0, 4, 0, 16'hFFFF, 1, 0, 1, 0));

    done = 1'b1;
  end

  // Watchdog so the bench always terminates
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
